// File: rtl/vx_lsu_req_arb_pkg.sv
// Shared types for the LSU request arbiter.
//   lsu_req_t  : one packed LSU request as seen on the request channels
//   LSU_REQ_W  : flattened width of lsu_req_t
//   arb_state_e: arbiter FSM states
package vx_lsu_req_arb_pkg;

  localparam int NW_BITS       = 2;
  localparam int NUM_THREADS   = 4;
  localparam int INST_LSU_BITS = 4;
  localparam int INST_MOD_BITS = 3;
  localparam int NR_BITS       = 5;

  typedef struct packed {
    logic [NW_BITS-1:0]          wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [31:0]                 pc;
    logic [INST_LSU_BITS-1:0]    op_type;
    logic [INST_MOD_BITS-1:0]    op_mod;
    logic                        is_amo;
    logic                        is_fence;
    logic [NUM_THREADS*32-1:0]   store_data;
    logic [NUM_THREADS*32-1:0]   base_addr;
    logic [31:0]                 offset;
    logic [NR_BITS-1:0]          rd;
    logic                        wb;
    logic                        is_prefetch;
  } lsu_req_t;

  localparam int LSU_REQ_W = $bits(lsu_req_t);

  typedef enum logic {
    ARB        = 1'b0,
    FENCE_WAIT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vx_lsu_req_arb_buf.sv
// Two-entry registered valid/ready FIFO placed between the arbiter and the LSU.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_data   : push side; caller only pushes when !full
//   out_valid, out_data : pop side, driven straight from storage registers
//   out_ready           : pop side accept
//   full, empty         : occupancy flags, registered
module vx_lsu_req_arb_buf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic             full,
  output logic             empty
);

  logic [DATAW-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  // A pop on a full buffer frees a slot only from the next cycle on,
  // because push is gated by the registered full flag.
  assign push = in_valid && !full;
  assign pop  = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: the storage array has no reset; count alone defines which entries
  // are live, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/vx_lsu_req_arb.sv
// Round-robin arbiter sharing one LSU request port between NUM_REQS requesters.
// Demand requests beat prefetches unless a prefetch has been starved for
// PF_STARVE_MAX demand grants. An accepted fence blocks further grants until
// the output buffer is empty and the LSU reports idle.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_data  : per-requester requests (packed lsu_req_t each)
//   req_ready           : per-requester accept, one-hot or zero
//   out_valid/out_data  : registered request to the LSU
//   out_ready           : LSU accepts
//   lsu_idle            : LSU has no outstanding memory operations
//   fence_busy          : arbiter is waiting for a fence to drain
module vx_lsu_req_arb
  import vx_lsu_req_arb_pkg::*;
#(
  parameter int NUM_REQS      = 4,
  parameter int PF_STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*LSU_REQ_W-1:0] req_data,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          out_valid,
  output logic [LSU_REQ_W-1:0]          out_data,
  input  logic                          out_ready,
  input  logic                          lsu_idle,
  output logic                          fence_busy
);

  localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CNT_W = $clog2(PF_STARVE_MAX + 1);

  arb_state_e          state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]    starve_cnt;

  lsu_req_t            reqs [NUM_REQS];
  logic [NUM_REQS-1:0] dmd_mask;
  logic [NUM_REQS-1:0] pf_mask;
  logic [NUM_REQS-1:0] cls_mask;
  logic                starve_hit;
  logic                sel_pf;
  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic                grant_fire;
  logic                buf_full;
  logic                buf_empty;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
    assign reqs[i]     = lsu_req_t'(req_data[i*LSU_REQ_W +: LSU_REQ_W]);
    assign dmd_mask[i] = req_valid[i] & ~reqs[i].is_prefetch;
    assign pf_mask[i]  = req_valid[i] &  reqs[i].is_prefetch;
  end

  // base + k modulo NUM_REQS with an explicit compare, so non-power-of-2
  // requester counts wrap correctly. base < NUM_REQS and k < NUM_REQS keep
  // the sum below 2*NUM_REQS, so one subtraction suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int k);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(k);
    if (sum >= (PTR_W+1)'(NUM_REQS)) sum = sum - (PTR_W+1)'(NUM_REQS);
    return sum[PTR_W-1:0];
  endfunction

  assign starve_hit = (starve_cnt == CNT_W'(PF_STARVE_MAX));
  assign sel_pf     = (|pf_mask) && (!(|dmd_mask) || starve_hit);
  assign cls_mask   = sel_pf ? pf_mask : dmd_mask;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!grant_any && cls_mask[wrap_add(rr_ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  // Grant depends only on requests and registered state, never on out_ready.
  assign grant_fire = (state == ARB) && !buf_full && grant_any;
  assign next_ptr   = (grant_idx == PTR_W'(NUM_REQS - 1)) ? '0
                                                          : grant_idx + PTR_W'(1);

  always_comb begin
    req_ready = '0;
    if (grant_fire) req_ready[grant_idx] = 1'b1;
  end

  assign fence_busy = (state == FENCE_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant_fire) rr_ptr <= next_ptr;

      if (!(|pf_mask) || (grant_fire && sel_pf)) begin
        starve_cnt <= '0;
      end else if (grant_fire && !starve_hit) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      case (state)
        ARB: begin
          // The fence itself is forwarded; only later grants are blocked.
          if (grant_fire && reqs[grant_idx].is_fence) state <= FENCE_WAIT;
        end
        FENCE_WAIT: begin
          if (buf_empty && lsu_idle) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  vx_lsu_req_arb_buf #(
    .DATAW (LSU_REQ_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (grant_fire),
    .in_data   (reqs[grant_idx]),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .full      (buf_full),
    .empty     (buf_empty)
  );

endmodule

// File: tb/tb_vx_lsu_req_arb.sv
// Bench for vx_lsu_req_arb. Two instances run side by side: dut_a with four
// requesters (directed scenarios, then random) and dut_b with three
// requesters (random, non-power-of-2 wrap). A reference model evaluated each
// cycle predicts the grant, pushes the granted request into an expected
// queue, and a separate monitor pops and compares whenever the LSU side
// transfers.
module tb_vx_lsu_req_arb;
  import vx_lsu_req_arb_pkg::*;

  localparam int STARVE = 8;
  localparam int DW     = NUM_THREADS * 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] vld  [2];
  lsu_req_t   req  [2][4];
  logic       ordy [2];
  logic       idle [2];

  logic [4*LSU_REQ_W-1:0] dat_a;
  logic [3*LSU_REQ_W-1:0] dat_b;
  logic [3:0] rdy_a;
  logic [2:0] rdy_b;
  logic       ov_a, ov_b, fb_a, fb_b;
  lsu_req_t   od_a, od_b;

  assign dat_a = {req[0][3], req[0][2], req[0][1], req[0][0]};
  assign dat_b = {req[1][2], req[1][1], req[1][0]};

  vx_lsu_req_arb #(.NUM_REQS(4), .PF_STARVE_MAX(STARVE)) dut_a (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_data(dat_a),
    .req_ready(rdy_a), .out_valid(ov_a), .out_data(od_a), .out_ready(ordy[0]),
    .lsu_idle(idle[0]), .fence_busy(fb_a)
  );

  vx_lsu_req_arb #(.NUM_REQS(3), .PF_STARVE_MAX(STARVE)) dut_b (
    .clk(clk), .reset(reset), .req_valid(vld[1][2:0]), .req_data(dat_b),
    .req_ready(rdy_b), .out_valid(ov_b), .out_data(od_b), .out_ready(ordy[1]),
    .lsu_idle(idle[1]), .fence_busy(fb_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- accessors ----------------
  function automatic logic [3:0] get_rdy(input int d);
    return (d == 0) ? rdy_a : {1'b0, rdy_b};
  endfunction
  function automatic logic get_ov(input int d);
    return (d == 0) ? ov_a : ov_b;
  endfunction
  function automatic logic get_fb(input int d);
    return (d == 0) ? fb_a : fb_b;
  endfunction
  function automatic lsu_req_t get_od(input int d);
    return (d == 0) ? od_a : od_b;
  endfunction

  // ---------------- reference model state ----------------
  lsu_req_t q0[$];
  lsu_req_t q1[$];
  int       m_rr     [2];
  int       m_starve [2];
  bit       m_fw     [2];
  int       glog[$];      // grant indices of dut_a, for directed checks

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction
  function automatic lsu_req_t qfront(input int d);
    lsu_req_t r;
    r = '0;
    if (d == 0 && q0.size() > 0) r = q0[0];
    if (d == 1 && q1.size() > 0) r = q1[0];
    return r;
  endfunction
  task automatic qpush(input int d, input lsu_req_t r);
    if (d == 0) q0.push_back(r); else q1.push_back(r);
  endtask
  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      m_rr[d] = 0; m_starve[d] = 0; m_fw[d] = 1'b0;
    end
  endtask

  function automatic lsu_req_t mk_req(input logic [31:0] pc, input bit pf, input bit fence);
    lsu_req_t r;
    r = '0;
    r.wid         = NW_BITS'($urandom());
    r.tmask       = NUM_THREADS'($urandom());
    r.pc          = pc;
    r.op_type     = INST_LSU_BITS'($urandom());
    r.op_mod      = INST_MOD_BITS'($urandom());
    r.is_amo      = 1'($urandom());
    r.is_fence    = fence;
    r.store_data  = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
    r.base_addr   = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
    r.offset      = $urandom();
    r.rd          = NR_BITS'($urandom());
    r.wb          = 1'($urandom());
    r.is_prefetch = pf;
    return r;
  endfunction

  // Evaluated once per cycle away from the edge: predicts which requester
  // (if any) is accepted at the coming edge and advances the model.
  task automatic model_cycle(input int d);
    int n, g, qs, idx;
    logic [3:0] dm, pm, cm, exp_rdy;
    n  = (d == 0) ? 4 : 3;
    qs = qsize(d);
    dm = '0; pm = '0;
    for (int i = 0; i < n; i++) begin
      if (vld[d][i]) begin
        if (req[d][i].is_prefetch) pm[i] = 1'b1; else dm[i] = 1'b1;
      end
    end
    g = -1;
    if (!m_fw[d] && qs < 2) begin
      cm = (pm != 0 && (dm == 0 || m_starve[d] == STARVE)) ? pm : dm;
      for (int k = 0; k < n; k++) begin
        idx = (m_rr[d] + k) % n;
        if (g < 0 && cm[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
    check(get_rdy(d) == exp_rdy, $sformatf("req_ready[dut%0d]", d), get_rdy(d), exp_rdy);
    check(get_fb(d) == m_fw[d], $sformatf("fence_busy[dut%0d]", d), get_fb(d), m_fw[d]);
    check(get_ov(d) == (qs > 0), $sformatf("out_valid[dut%0d]", d), get_ov(d), qs > 0);
    check(!(get_fb(d) && get_rdy(d) != 0), $sformatf("grant_in_fence_wait[dut%0d]", d),
          get_rdy(d), 0);

    if (g >= 0) begin
      qpush(d, req[d][g]);
      m_rr[d] = (g + 1) % n;
      if (d == 0) glog.push_back(g);
    end
    if (pm == 0 || (g >= 0 && req[d][g].is_prefetch)) m_starve[d] = 0;
    else if (g >= 0 && m_starve[d] < STARVE) m_starve[d]++;
    if (m_fw[d]) begin
      if (qs == 0 && idle[d]) m_fw[d] = 1'b0;
    end else if (g >= 0 && req[d][g].is_fence) begin
      m_fw[d] = 1'b1;
    end
  endtask

  // Monitor: compares the LSU-side output with the expected queue.
  always begin
    lsu_req_t e, a;
    @(negedge clk);
    #1;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (get_ov(d)) begin
          e = qfront(d);
          a = get_od(d);
          check(qsize(d) > 0 && a == e, $sformatf("out_data_pc[dut%0d]", d), a.pc, e.pc);
          if (ordy[d] && qsize(d) > 0) qpop(d);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (!reset) begin
      for (int d = 0; d < 2; d++) model_cycle(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vld[0] = '0; vld[1] = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_glog(input string name, input int pos, input int exp);
    int v;
    v = (pos < glog.size()) ? glog[pos] : -1;
    check(v == exp, $sformatf("%s[%0d]", name, pos), v, exp);
  endtask

  initial begin
    lsu_req_t h;
    for (int d = 0; d < 2; d++) begin
      vld[d] = '0; ordy[d] = 1'b1; idle[d] = 1'b1;
      for (int i = 0; i < 4; i++) req[d][i] = '0;
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check(ov_a == 1'b0, "reset_out_valid", ov_a, 0);
    check(fb_a == 1'b0, "reset_fence_busy", fb_a, 0);
    check(rdy_a == 4'h0, "reset_req_ready", rdy_a, 0);

    // Round robin: all four demand requesters valid
    glog.delete();
    for (int i = 0; i < 4; i++) req[0][i] = mk_req(32'h10 + 32'(i), 1'b0, 1'b0);
    vld[0] = 4'hf;
    repeat (5) step();
    vld[0] = '0;
    for (int i = 0; i < 5; i++) check_glog("rr_order", i, i % 4);
    repeat (3) step();

    // Demand priority and starvation guard: req1 demand, req3 prefetch
    glog.delete();
    req[0][1] = mk_req(32'h21, 1'b0, 1'b0);
    req[0][3] = mk_req(32'h23, 1'b1, 1'b0);
    vld[0] = 4'b1010;
    repeat (10) step();
    vld[0] = '0;
    for (int i = 0; i < 10; i++) check_glog("starve", i, (i == 8) ? 3 : 1);
    repeat (3) step();

    // Fence serialization
    glog.delete();
    idle[0] = 1'b0;
    req[0][0] = mk_req(32'h100, 1'b0, 1'b1);
    vld[0] = 4'b0001;
    step();
    req[0][2] = mk_req(32'h200, 1'b0, 1'b0);
    vld[0] = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step();
      check(fb_a == 1'b1, "fence_busy_held", fb_a, 1);
      check(rdy_a == 4'h0, "fence_no_grant", rdy_a, 0);
    end
    idle[0] = 1'b1;
    step();
    check(fb_a == 1'b0, "fence_released", fb_a, 0);
    step();
    vld[0] = '0;
    check(glog.size() == 2, "fence_grant_count", glog.size(), 2);
    check_glog("fence_order", 0, 0);
    check_glog("fence_order", 1, 2);
    repeat (3) step();

    // Backpressure: exactly two accepts, head stays stable
    glog.delete();
    ordy[0] = 1'b0;
    vld[0] = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      req[0][0] = mk_req(32'h400 + 32'(c), 1'b0, 1'b0);
      step();
    end
    h = od_a;
    check(glog.size() == 2, "bp_accepts", glog.size(), 2);
    check(ov_a && h.pc == 32'h400, "bp_head_pc", h.pc, 32'h400);
    check(rdy_a == 4'h0, "bp_full_no_ready", rdy_a, 0);
    vld[0] = '0;
    ordy[0] = 1'b1;
    repeat (4) step();
    check(qsize(0) == 0, "bp_drained", qsize(0), 0);

    // Reset while full and in FENCE_WAIT
    ordy[0] = 1'b0;
    idle[0] = 1'b0;
    req[0][2] = mk_req(32'h500, 1'b0, 1'b0);
    vld[0] = 4'b0100;
    step();
    req[0][2] = mk_req(32'h504, 1'b0, 1'b1);
    step();
    vld[0] = '0;
    step();
    check(fb_a == 1'b1 && ov_a == 1'b1 && qsize(0) == 2, "pre_reset_full_fence",
          {fb_a, ov_a}, 2'b11);
    do_reset();
    check(ov_a == 1'b0, "midreset_out_valid", ov_a, 0);
    check(fb_a == 1'b0, "midreset_fence_busy", fb_a, 0);
    check(rdy_a == 4'h0, "midreset_req_ready", rdy_a, 0);
    ordy[0] = 1'b1;
    idle[0] = 1'b1;
    glog.delete();
    req[0][1] = mk_req(32'h601, 1'b0, 1'b0);
    req[0][3] = mk_req(32'h603, 1'b0, 1'b0);
    vld[0] = 4'b1010;
    step();
    vld[0] = '0;
    check_glog("post_reset_first", 0, 1);
    repeat (3) step();

    // Random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          vld[d][i] = (d == 1 && i == 3) ? 1'b0 : 1'($urandom_range(0, 1));
          req[d][i] = mk_req($urandom(), $urandom_range(0, 2) == 0,
                             $urandom_range(0, 15) == 0);
        end
        ordy[d] = ($urandom_range(0, 3) != 0);
        idle[d] = 1'($urandom_range(0, 1));
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      vld[d] = '0; ordy[d] = 1'b1; idle[d] = 1'b1;
    end
    repeat (10) step();
    check(qsize(0) == 0 && ov_a == 1'b0, "random_drain_a", qsize(0), 0);
    check(qsize(1) == 0 && ov_b == 1'b0, "random_drain_b", qsize(1), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
